de_adpcm: RTL and testbench

Decoder paired with the ADPCM-like pixel encoder on the HDMI transport path. It accepts an alternating stream of 16-bit words. Even words (eo=0) are raw anchor pixels. Odd words (eo=1) carry per-channel quantized difference codes relative to the preceding anchor. The block reconstructs full 8-bit Y and CbCr samples and sits on the receive side before pixel reassembly.

---
 rtl/de_adpcm_if.sv | 20 ++
 rtl/de_adpcm.sv | 143 ++++++++++++++
 tb/tb_de_adpcm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/de_adpcm_if.sv
// de_adpcm_if: word stream between the HDMI receive path and the ADPCM decoder.
// The master drives phase/valid/data words; the slave returns reconstructed pixels.
interface de_adpcm_if;
  logic        eo;
  logic        in_en;
  logic [15:0] din;
  logic        out_en;
  logic [15:0] dout;
  logic        seq_err;

  modport master (
    output eo, in_en, din,
    input  out_en, dout, seq_err
  );

  modport slave (
    input  eo, in_en, din,
    output out_en, dout, seq_err
  );
endinterface

// File: rtl/de_adpcm.sv
// de_adpcm: ADPCM-like pixel decoder. Alternating anchor (eo=0) and delta (eo=1)
// words are turned back into {CbCr, Y} samples with a fixed 2-cycle latency.
// Optional macro ADPCM_SAT_EN: channels saturate to 0..255 instead of wrapping.
module de_adpcm #(
  parameter int unsigned CODE_MAX    = 8,
  parameter int unsigned SCALE_NUM   = 254,
  parameter int unsigned SCALE_SHIFT = 3
) (
  input  logic          clk,
  input  logic          rst,
  de_adpcm_if.slave     bus
);

  typedef enum logic {IDLE, ANCH} state_t;

  localparam logic [11:0] ROUND = 12'(1 << (SCALE_SHIFT - 1));

  state_t      state, state_nx;
  logic [15:0] anchor, anchor_nx;
  logic        err_nx;

  logic        s1_v, s1_eo, s1_err;
  logic [15:0] s1_base;
  logic        s1_sy, s1_sc;
  logic [7:0]  s1_stepy, s1_stepc;

  logic [15:0] res;
  logic        out_q, err_q;
  logic [15:0] dout_q;

  // Magnitude code -> step size, with clamping of out-of-range magnitudes.
  function automatic logic [7:0] step_of(input logic [3:0] mag);
    logic [11:0] m;
    logic [11:0] p;
    m = (32'(mag) > CODE_MAX) ? 12'(CODE_MAX) : {8'b0, mag};
    p = m * 12'(SCALE_NUM) + ROUND;
    return 8'(p >> SCALE_SHIFT);
  endfunction

  // Apply one signed step to one anchor byte, then wrap or saturate.
  function automatic logic [7:0] chan(input logic [7:0] base, input logic sub,
                                      input logic [7:0] step);
    logic signed [9:0] sum;
    sum = sub ? ($signed({2'b00, base}) - $signed({2'b00, step}))
              : ($signed({2'b00, base}) + $signed({2'b00, step}));
`ifdef ADPCM_SAT_EN
    if (sum < 0)             return 8'h00;
    else if (sum > 10'sd255) return 8'hFF;
    else                     return sum[7:0];
`else
    return sum[7:0];
`endif
  endfunction

  // Phase FSM: next state, anchor update and sequence-error detection.
  always_comb begin
    state_nx  = state;
    anchor_nx = anchor;
    err_nx    = 1'b0;
    if (bus.in_en) begin
      case (state)
        IDLE: begin
          if (!bus.eo) begin
            anchor_nx = bus.din;
            state_nx  = ANCH;
          end else begin
            err_nx = 1'b1;
          end
        end
        ANCH: begin
          if (bus.eo) begin
            state_nx = IDLE;
          end else begin
            anchor_nx = bus.din;
            err_nx    = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM state and anchor register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      anchor <= '0;
    end else begin
      state  <= state_nx;
      anchor <= anchor_nx;
    end
  end

  // Stage 1: capture the word, the anchor it decodes against, and the steps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v     <= 1'b0;
      s1_eo    <= 1'b0;
      s1_err   <= 1'b0;
      s1_base  <= '0;
      s1_sy    <= 1'b0;
      s1_sc    <= 1'b0;
      s1_stepy <= '0;
      s1_stepc <= '0;
    end else begin
      s1_v   <= bus.in_en;
      s1_err <= bus.in_en & err_nx;
      if (bus.in_en) begin
        s1_eo    <= bus.eo;
        s1_base  <= bus.eo ? anchor : bus.din;
        s1_sy    <= bus.din[7];
        s1_sc    <= bus.din[15];
        s1_stepy <= step_of(bus.din[3:0]);
        s1_stepc <= step_of(bus.din[11:8]);
      end
    end
  end

  // Stage 2 datapath: anchors pass through, deltas are applied per channel.
  always_comb begin
    res = s1_base;
    if (s1_eo)
      res = {chan(s1_base[15:8], s1_sc, s1_stepc), chan(s1_base[7:0], s1_sy, s1_stepy)};
  end

  // Stage 2 output register; data forced to zero when not valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      out_q  <= s1_v;
      err_q  <= s1_v & s1_err;
      dout_q <= s1_v ? res : '0;
    end
  end

  assign bus.out_en  = out_q;
  assign bus.seq_err = err_q;
  assign bus.dout    = dout_q;

endmodule

// File: tb/tb_de_adpcm.sv
// tb_de_adpcm: scoreboard bench for de_adpcm. The driver pushes expected
// {dout, seq_err, due cycle} from an arithmetic reference model; a monitor
// compares whenever the DUT presents out_en and checks idle outputs otherwise.
module tb_de_adpcm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  de_adpcm_if bus();

  de_adpcm #(.CODE_MAX(8), .SCALE_NUM(254), .SCALE_SHIFT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] d;
    logic        e;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;

  logic [15:0] m_anchor = 16'h0000;
  bit          m_held   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: one channel, straight from the code/step rules.
  function automatic logic [7:0] ref_chan(input logic [7:0] base, input logic [7:0] code);
    int mag, step, v;
    mag = int'(code[3:0]);
    if (mag > 8) mag = 8;
    step = (mag * 254 + 4) / 8;
    v = code[7] ? int'(base) - step : int'(base) + step;
`ifdef ADPCM_SAT_EN
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
`endif
    return v[7:0];
  endfunction

  task automatic send(input logic eo, input logic [15:0] d);
    exp_t x;
    @(posedge clk); #1;
    bus.in_en = 1'b1;
    bus.eo    = eo;
    bus.din   = d;
    if (!eo) begin
      x.d = d;
      x.e = m_held;
      m_anchor = d;
      m_held   = 1'b1;
    end else begin
      x.d = {ref_chan(m_anchor[15:8], d[15:8]), ref_chan(m_anchor[7:0], d[7:0])};
      x.e = !m_held;
      m_held = 1'b0;
    end
    x.due = cyc + 2;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_en = 1'b0;
      bus.eo    = 1'($urandom);
      bus.din   = 16'($urandom);
    end
  endtask

  // Assert reset for n edges; words that would emerge on or after the first
  // reset edge are dropped from the expectation queue.
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    bus.in_en = 1'b0;
    rst = 1'b0;
    while (q.size() > 0 && q[q.size()-1].due >= cyc + 1) void'(q.pop_back());
    m_anchor = 16'h0000;
    m_held   = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: compare on every valid output, check quiet outputs otherwise.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bus.out_en === 1'b1) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_out: got dout=%h seq_err=%b at cyc %0d, required no output",
                   bus.dout, bus.seq_err, cyc);
        end else begin
          exp_t x;
          x = q.pop_front();
          if (bus.dout !== x.d || bus.seq_err !== x.e || cyc != x.due) begin
            mismatched++;
            $display("FAIL word: got dout=%h seq_err=%b cyc=%0d, required dout=%h seq_err=%b cyc=%0d",
                     bus.dout, bus.seq_err, cyc, x.d, x.e, x.due);
          end
        end
      end else begin
        compared++;
        if (bus.out_en !== 1'b0 || bus.dout !== 16'h0000 || bus.seq_err !== 1'b0) begin
          mismatched++;
          $display("FAIL idle_out: got out_en=%b dout=%h seq_err=%b at cyc %0d, required 0/0000/0",
                   bus.out_en, bus.dout, bus.seq_err, cyc);
        end
      end
      if (q.size() > 0 && q[0].due < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missing_out: got nothing by cyc %0d, required dout=%h due cyc %0d",
                 cyc, q[0].d, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.in_en = 1'b0;
    bus.eo    = 1'b0;
    bus.din   = 16'h0000;

    do_reset(3);
    idle(3);

    send(1'b0, 16'h4080); send(1'b1, 16'h0402); idle(2);
    send(1'b0, 16'h1010); send(1'b1, 16'h8888);
    send(1'b0, 16'h0000); send(1'b1, 16'h000F);
    send(1'b0, 16'hF0F0); send(1'b1, 16'h0808); idle(2);

    do_reset(1);
    send(1'b1, 16'h0101);
    send(1'b0, 16'h1111); send(1'b0, 16'h2222); send(1'b1, 16'h0000); idle(2);

    send(1'b0, 16'hABCD);
    do_reset(1);
    send(1'b1, 16'h0101); idle(3);

    for (int i = 0; i < 800; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2)       do_reset(1 + int'($urandom_range(0, 2)));
      else if (r < 25) idle(1);
      else begin
        logic e;
        e = ($urandom_range(0, 99) < 85) ? logic'(m_held) : logic'(!m_held);
        send(e, 16'($urandom));
      end
    end

    idle(6);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d words still pending, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
